// File: rtl/snn_pkg.sv
`default_nettype none
// ============================================================================
// Module : snn_pkg
// Brief  : Shared types and constants for the spiking front-end: encoder
//          state type, LFSR tap mask, per-lane seed spread, default lane
//          count (shared with the lif neuron array), and an LFSR step helper.
// Rev    : 1.0  initial release
// ============================================================================
package snn_pkg;

   // Encoder control states
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } lane_t;

   // Default number of spike lanes; matches the lif spike_in width
   localparam int c_lanes = 8;

   // Fibonacci taps 16, 14, 13, 11 expressed as bit positions 15, 13, 12, 10
   localparam logic [15:0] c_lfsr_taps = 16'hB400;

   // Lane i seed = base seed ^ (i * c_seed_spread)
   localparam logic [15:0] c_seed_spread = 16'h0101;

   // One shift toward the MSB with the XOR of the tapped bits entering at bit 0
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], ^(s & c_lfsr_taps)};
   endfunction

endpackage
`default_nettype wire

// File: rtl/spike_rate_encoder_if.sv
`default_nettype none
// ============================================================================
// Module : spike_rate_encoder_if
// Brief  : Frame-in and spike-out valid/ready channels of the rate encoder.
//          master : frame producer / spike consumer side
//          slave  : the encoder itself
//          in_valid/in_ready/in_values/num_steps   - frame handshake
//          spike_valid/spike_ready/spike_out       - timestep handshake
// Rev    : 1.0  initial release
// ============================================================================
interface spike_rate_encoder_if
   import snn_pkg::*;
#(
   parameter int LANES   = c_lanes,
   parameter int VALUE_W = 8,
   parameter int STEP_W  = 8
);
   logic                       in_valid;
   logic                       in_ready;
   logic [LANES*VALUE_W-1:0]   in_values;
   logic [STEP_W-1:0]          num_steps;
   logic                       spike_valid;
   logic                       spike_ready;
   logic [LANES-1:0]           spike_out;

   modport master (
      output in_valid, in_values, num_steps, spike_ready,
      input  in_ready, spike_valid, spike_out
   );

   modport slave (
      input  in_valid, in_values, num_steps, spike_ready,
      output in_ready, spike_valid, spike_out
   );
endinterface
`default_nettype wire

// File: rtl/spike_lfsr16.sv
`default_nettype none
// ============================================================================
// Module : spike_lfsr16
// Brief  : 16-bit Fibonacci LFSR (taps 16,14,13,11) that steps only when
//          advance is high.
//          clk     - rising-edge clock
//          reset_n - asynchronous active-low reset, loads SEED
//          advance - step enable
//          state   - current LFSR contents
// Rev    : 1.0  initial release
// ============================================================================
module spike_lfsr16
   import snn_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  wire logic        clk,
   input  wire logic        reset_n,
   input  wire logic        advance,
   output logic [15:0]      state
);

   // An all-zero seed would lock the register at zero forever
   if (SEED == 16'h0000) begin : g_seed_check
      $error("spike_lfsr16: SEED must be nonzero");
   end

   logic [15:0] state_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= SEED;
      end else if (advance) begin
         state_q <= lfsr_next(state_q);
      end
   end

   assign state = state_q;

endmodule
`default_nettype wire

// File: rtl/spike_rate_encoder.sv
`default_nettype none
// ============================================================================
// Module : spike_rate_encoder
// Brief  : Bernoulli rate encoder. Accepts a frame of LANES intensities and
//          emits num_steps spike vectors; lane i fires when the low bits of
//          its private LFSR are below the lane intensity.
//          clk        - rising-edge clock
//          reset_n    - asynchronous active-low reset
//          bus        - frame-in and spike-out handshakes (slave side)
//          frame_done - one-cycle pulse after the last timestep of a frame
//          busy       - high while timesteps are being delivered
// Rev    : 1.0  initial release
// ============================================================================
module spike_rate_encoder
   import snn_pkg::*;
#(
   parameter int          LANES     = c_lanes,
   parameter int          VALUE_W   = 8,
   parameter int          STEP_W    = 8,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  wire logic             clk,
   input  wire logic             reset_n,
   spike_rate_encoder_if.slave   bus,
   output logic                  frame_done,
   output logic                  busy
);

   lane_t                             state_q, state_d;
   logic [STEP_W-1:0]                 count_q, count_d;
   logic [LANES-1:0][VALUE_W-1:0]     value_q, value_d;
   logic                              frame_done_q, frame_done_d;

   logic                              w_in_ready;
   logic                              w_spike_valid;
   logic                              w_advance;
   logic [LANES-1:0][15:0]            w_lfsr_state;
   logic [LANES-1:0]                  w_spike_vec;
   // Upper LFSR bits take no part in the compare
   logic [LANES-1:0]                  w_lfsr_hi_unused;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      spike_lfsr16 #(
         .SEED (LFSR_SEED ^ (16'(i) * c_seed_spread))
      ) u_lfsr (
         .clk     (clk),
         .reset_n (reset_n),
         .advance (w_advance),
         .state   (w_lfsr_state[i])
      );
      assign w_lfsr_hi_unused[i] = ^w_lfsr_state[i][15:VALUE_W];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         count_q      <= '0;
         value_q      <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         value_q      <= value_d;
         frame_done_q <= frame_done_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      value_d       = value_q;
      frame_done_d  = 1'b0;
      w_in_ready    = 1'b0;
      w_spike_valid = 1'b0;
      w_advance     = 1'b0;
      case (state_q)
         IDLE: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) begin
               for (int i = 0; i < LANES; i++) begin
                  value_d[i] = bus.in_values[i*VALUE_W +: VALUE_W];
               end
               count_d = bus.num_steps;
               // An empty frame completes immediately without touching the LFSRs
               if (bus.num_steps != '0) begin
                  state_d = RUN;
               end else begin
                  frame_done_d = 1'b1;
               end
            end
         end
         RUN: begin
            w_spike_valid = 1'b1;
            if (bus.spike_ready) begin
               w_advance = 1'b1;
               count_d   = count_q - STEP_W'(1);
               if (count_q == STEP_W'(1)) begin
                  state_d      = IDLE;
                  frame_done_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Purely register-driven, so the vector holds steady under backpressure
   always_comb begin
      w_spike_vec = '0;
      for (int i = 0; i < LANES; i++) begin
         w_spike_vec[i] = (state_q == RUN) &&
                          (w_lfsr_state[i][VALUE_W-1:0] < value_q[i]);
      end
   end

   assign bus.in_ready    = w_in_ready;
   assign bus.spike_valid = w_spike_valid;
   assign bus.spike_out   = w_spike_vec;
   assign frame_done      = frame_done_q;
   assign busy            = (state_q == RUN);

endmodule
`default_nettype wire

// File: tb/tb_spike_rate_encoder.sv
`default_nettype none
// ============================================================================
// Module : tb_spike_rate_encoder
// Brief  : Self-checking bench for spike_rate_encoder. A frame-level model
//          turns each accepted frame into its list of expected spike vectors;
//          a compare process checks every output on every falling edge.
// Rev    : 1.0  initial release
// ============================================================================
module tb_spike_rate_encoder;
   import snn_pkg::*;

   localparam logic [63:0] c_graded = 64'hE0C0_A080_6040_2000;
   localparam logic [63:0] c_all_ff = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] c_zeros  = 64'h0;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   logic frame_done;
   logic busy;

   spike_rate_encoder_if bus ();

   spike_rate_encoder dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .bus        (bus),
      .frame_done (frame_done),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Model state
   logic [15:0] m_lfsr [8];
   int          m_vals [8];
   logic [7:0]  exp_q [$];
   logic        m_done = 1'b0;

   // Observations
   logic [7:0]  obs [$];
   int          hs_total   = 0;
   int          done_total = 0;
   int          lane_cnt [8] = '{default: 0};
   logic [7:0]  ref_vec [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic chk_range(input string name, input int lane, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         failures++;
         $display("FAIL %s lane=%0d actual=%0d required=%0d..%0d", name, lane, act, lo, hi);
      end
   endtask

   // One LFSR step: taps 16,14,13,11 (1-based) feed bit 0, contents move toward the MSB
   function automatic logic [15:0] ref_step(input logic [15:0] s);
      logic fb;
      fb = s[16-1] ^ s[14-1] ^ s[13-1] ^ s[11-1];
      return {s[14:0], fb};
   endfunction

   // Expand an accepted frame into its full list of timestep vectors
   task automatic model_frame(input int steps);
      logic [7:0] v;
      for (int t = 0; t < steps; t++) begin
         for (int i = 0; i < 8; i++) begin
            v[i]      = (int'(m_lfsr[i][7:0]) < m_vals[i]);
            m_lfsr[i] = ref_step(m_lfsr[i]);
         end
         exp_q.push_back(v);
      end
   endtask

   always @(negedge clk) begin : p_compare
      logic       run;
      logic [7:0] exp_vec;
      if (!reset_n) begin
         chk("rst_in_ready",    32'(bus.in_ready),    1);
         chk("rst_spike_valid", 32'(bus.spike_valid), 0);
         chk("rst_spike_out",   32'(bus.spike_out),   0);
         chk("rst_frame_done",  32'(frame_done),      0);
         chk("rst_busy",        32'(busy),            0);
         exp_q.delete();
         m_done = 1'b0;
         for (int i = 0; i < 8; i++) m_lfsr[i] = 16'hACE1 ^ (16'(i) * 16'h0101);
      end else begin
         run     = (exp_q.size() != 0);
         exp_vec = run ? exp_q[0] : 8'h00;
         chk("in_ready",    32'(bus.in_ready),    32'(!run));
         chk("spike_valid", 32'(bus.spike_valid), 32'(run));
         chk("busy",        32'(busy),            32'(run));
         chk("frame_done",  32'(frame_done),      32'(m_done));
         chk("spike_out",   32'(bus.spike_out),   32'(exp_vec));
         if (frame_done === 1'b1) done_total++;
         m_done = 1'b0;
         if (run) begin
            if (bus.spike_ready) begin
               obs.push_back(bus.spike_out);
               for (int i = 0; i < 8; i++) lane_cnt[i] += int'(bus.spike_out[i]);
               hs_total++;
               void'(exp_q.pop_front());
               if (exp_q.size() == 0) m_done = 1'b1;
            end
         end else if (bus.in_valid) begin
            for (int i = 0; i < 8; i++) m_vals[i] = int'(bus.in_values[i*8 +: 8]);
            if (bus.num_steps == 8'd0) m_done = 1'b1;
            else model_frame(int'(bus.num_steps));
         end
      end
   end

   task automatic reset_pulse();
      @(posedge clk); #1;
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
   endtask

   // Only called while the encoder is idle, so the frame is taken on the next edge
   task automatic send(input logic [63:0] v, input logic [7:0] n);
      @(posedge clk); #1;
      bus.in_valid  = 1'b1;
      bus.in_values = v;
      bus.num_steps = n;
      @(posedge clk); #1;
      bus.in_valid  = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < budget && !seen; k++) begin
         @(negedge clk);
         if (frame_done === 1'b1) seen = 1'b1;
      end
      #1;
      chk("frame_done_seen", 32'(seen), 1);
   endtask

   // Returns just after the rising edge that completes the n-th handshake since base
   task automatic wait_hs(input int base, input int n, input int budget);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < budget && !ok; k++) begin
         @(posedge clk); #1;
         if (hs_total - base >= n) ok = 1'b1;
      end
      chk("hs_wait", 32'(ok), 1);
   endtask

   initial begin : p_watchdog
      #300000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : p_main
      int b_obs, b_hs, b_done, nz, expc;
      int snap [8];

      bus.in_valid    = 1'b0;
      bus.in_values   = '0;
      bus.num_steps   = '0;
      bus.spike_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      // Hand-derived LFSR steps pin the model
      chk("model_step_lane0", 32'(ref_step(16'hACE1)), 32'h59C3);
      chk("model_step_lane1", 32'(ref_step(16'hADE0)), 32'h5BC1);

      @(negedge clk); #1;
      chk("idle_in_ready",    32'(bus.in_ready),    1);
      chk("idle_spike_valid", 32'(bus.spike_valid), 0);
      chk("idle_spike_out",   32'(bus.spike_out),   0);
      chk("idle_busy",        32'(busy),            0);

      // All 255, 200 steps, from seeds
      b_obs = obs.size(); b_hs = hs_total;
      for (int i = 0; i < 8; i++) snap[i] = lane_cnt[i];
      send(c_all_ff, 8'd200);
      wait_done(400);
      chk("ff_handshakes", 32'(hs_total - b_hs), 200);
      chk("ff_first_vec",  32'(obs[b_obs]), 32'hFF);
      for (int i = 0; i < 8; i++) chk_range("ff_lane_count", i, lane_cnt[i] - snap[i], 195, 200);

      // Graded values, 255 steps, from seeds; frames offered mid-run are ignored
      reset_pulse();
      b_obs = obs.size(); b_hs = hs_total;
      for (int i = 0; i < 8; i++) snap[i] = lane_cnt[i];
      send(c_graded, 8'd255);
      repeat (5) @(posedge clk);
      #1;
      bus.in_valid = 1'b1; bus.in_values = c_all_ff; bus.num_steps = 8'd3;
      repeat (10) @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      wait_done(600);
      chk("grad_handshakes", 32'(hs_total - b_hs), 255);
      chk("grad_vec0", 32'(obs[b_obs]),     32'h00);
      chk("grad_vec1", 32'(obs[b_obs + 1]), 32'h80);
      for (int i = 0; i < 8; i++) begin
         expc = (32 * i * 255) / 256;
         chk_range("grad_lane_count", i, lane_cnt[i] - snap[i], expc - 24, expc + 24);
      end

      // All zero, 16 steps, LFSR state carried over
      b_obs = obs.size(); b_hs = hs_total;
      send(c_zeros, 8'd16);
      wait_done(100);
      chk("zero_handshakes", 32'(hs_total - b_hs), 16);
      nz = 0;
      for (int k = 0; k < 16; k++) if (obs[b_obs + k] != 8'h00) nz++;
      chk("zero_nonzero_vecs", 32'(nz), 0);

      // Reference 10-step run from seeds
      reset_pulse();
      b_obs = obs.size();
      send(c_graded, 8'd10);
      wait_done(100);
      for (int k = 0; k < 10; k++) ref_vec[k] = obs[b_obs + k];

      // Same run with a 5-cycle stall after the third handshake
      reset_pulse();
      b_obs = obs.size(); b_hs = hs_total;
      send(c_graded, 8'd10);
      wait_hs(b_hs, 3, 50);
      bus.spike_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_hold", 32'(bus.spike_out), 32'(ref_vec[3]));
      end
      @(posedge clk); #1;
      bus.spike_ready = 1'b1;
      wait_done(100);
      chk("stall_handshakes", 32'(hs_total - b_hs), 10);
      for (int k = 0; k < 10; k++) chk("stall_vs_nostall", 32'(obs[b_obs + k]), 32'(ref_vec[k]));

      // Empty frame immediately followed by a 4-step frame
      reset_pulse();
      b_obs = obs.size(); b_hs = hs_total; b_done = done_total;
      @(posedge clk); #1;
      bus.in_valid = 1'b1; bus.in_values = c_graded; bus.num_steps = 8'd0;
      @(posedge clk); #1;
      bus.num_steps = 8'd4;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      wait_done(50);
      chk("zero_then4_done_pulses", 32'(done_total - b_done), 2);
      chk("zero_then4_handshakes",  32'(hs_total - b_hs), 4);
      for (int k = 0; k < 4; k++) chk("zero_then4_vs_fresh", 32'(obs[b_obs + k]), 32'(ref_vec[k]));

      // Reset during step 5 of 20, then a full 20-step frame
      reset_pulse();
      b_hs = hs_total;
      send(c_graded, 8'd20);
      wait_hs(b_hs, 5, 50);
      reset_n = 1'b0;
      @(negedge clk);
      chk("midrst_in_ready",    32'(bus.in_ready),    1);
      chk("midrst_spike_valid", 32'(bus.spike_valid), 0);
      chk("midrst_busy",        32'(busy),            0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      b_obs = obs.size(); b_hs = hs_total;
      send(c_graded, 8'd20);
      wait_done(100);
      chk("after_rst_handshakes", 32'(hs_total - b_hs), 20);
      for (int k = 0; k < 10; k++) chk("after_rst_vs_seed", 32'(obs[b_obs + k]), 32'(ref_vec[k]));

      repeat (3) @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/spike_rate_encoder.md
# spike_rate_encoder

Converts a frame of eight 8-bit intensity values into Bernoulli rate-coded spike trains. Each frame produces a configurable number of timesteps. Each timestep delivers one 8-lane spike vector to the `spike_in` port of the downstream `lif` neuron array. Frames arrive over a valid/ready handshake, and spike vectors leave over a second valid/ready handshake.

## Interface

**Parameters**
- `LANES`, 8: number of spike lanes; equals neuron `spike_in` width.
- `VALUE_W`, 8: intensity width per lane.
- `STEP_W`, 8: width of `num_steps`.
- `LFSR_SEED`, 16'hACE1: base seed. Must be nonzero.

**Ports**
- `clk`, in, 1: single clock. All logic is rising-edge.
- `reset_n`, in, 1: reset. **Asynchronous, active-low.**
- `in_valid`, in, 1: frame offered.
- `in_ready`, out, 1: encoder can accept a frame.
- `in_values`, in, `LANES*VALUE_W`: lane i is `[i*VALUE_W +: VALUE_W]`.
- `num_steps`, in, `STEP_W`: timesteps for this frame. Sampled at accept.
- `spike_valid`, out, 1: `spike_out` holds a valid timestep.
- `spike_ready`, in, 1: consumer accepts the timestep.
- `spike_out`, out, `LANES`: spike vector, bit i is lane i.
- `frame_done`, out, 1: one-cycle pulse when a frame finishes.
- `busy`, out, 1: high while in RUN.

## Operation

- **FSM state IDLE.**
  - `in_ready` = 1.
  - On `in_valid & in_ready`, latch `in_values` into value registers and load the step counter with `num_steps`.
  - If `num_steps` != 0, go to RUN.
  - If `num_steps` == 0, stay in IDLE and pulse `frame_done` next cycle. No spikes are emitted and the LFSRs do not change.
- **FSM state RUN.**
  - `in_ready` = 0, `spike_valid` = 1.
  - `spike_out[i]` = (`lfsr_i[7:0]` < `value_i`), unsigned compare.
  - Value 0 never spikes. Value 255 spikes unless `lfsr_i[7:0]` == 255.
- **Handshake (`spike_valid & spike_ready`).**
  - All LFSRs advance exactly one step and the step counter decrements.
  - If the counter was 1, go to IDLE and set `frame_done` for the next cycle.
- **LFSRs.**
  - One 16-bit Fibonacci LFSR per lane, taps 16, 14, 13, 11, shifting toward the MSB.
  - Reset seed for lane i = `LFSR_SEED ^ (i * 16'h0101)`. This must be nonzero, and a parameter elaboration check enforces it.
  - LFSRs are not reseeded between frames; state carries over.
  - LFSRs advance only on output handshakes.
- **Backpressure.** While `spike_valid & !spike_ready`, `spike_out`, the LFSRs, the counter and the value registers hold unchanged.
- **Reset.**
  - Asserting `reset_n` low at any time aborts any in-flight frame.
  - Reset values: state IDLE, `in_ready`=1, `spike_valid`=0, `spike_out`=0, `frame_done`=0, `busy`=0, counter 0, values 0, LFSRs at seeds.

## Timing

- Frame accepted at cycle T:
  - `spike_valid` = 1 and `busy` = 1 at T+1.
  - The first `spike_out` is computed from the seed or carried-over LFSR state.
- `spike_out` is a function of registers only. It is stable for the whole cycle, with no combinational path from `spike_ready`.
- Last handshake at cycle L:
  - At L+1: `spike_valid`=0, `busy`=0, `in_ready`=1, `frame_done`=1, all in the same cycle.
  - A new frame can be accepted at L+1.
- Throughput with `spike_ready` held high: `num_steps` + 1 cycles per frame.
- `num_steps`=0 accepted at T: `frame_done`=1 at T+1, and `in_ready` stays 1 throughout.
- `in_values` and `num_steps` are ignored whenever `in_ready`=0.

## Structure

- **Package `snn_pkg`** holds:
  - `lane_t` enum/state typedef (`IDLE`, `RUN`).
  - LFSR tap localparam.
  - Seed-spread constant 16'h0101.
  - `LANES` default, shared with `lif`.
- **Sub-module `spike_lfsr16`**:
  - Parameter `SEED`; ports `clk`, `reset_n`, `advance`, `state[15:0]`.
  - The top level instantiates `LANES` copies in a generate loop.
- **Top level** contains the FSM, step counter, value registers and comparators.

## Test plan

- All values 0, `num_steps`=16, `spike_ready`=1:
  - Exactly 16 `spike_valid` cycles, `spike_out`=8'h00 every step.
  - `frame_done` one cycle after the 16th handshake.
- All values 255, `num_steps`=200:
  - Every lane's spike count matches the bit-exact software LFSR model, and is ≥ 195.
- Values 0, 32, 64, 96, 128, 160, 192, 224, `num_steps`=255:
  - Per-lane counts bit-exact with the model.
  - Each count is within ±24 of value×255/256.
- Backpressure: `spike_ready`=0 for 5 cycles at step 3 of 10:
  - `spike_out` is unchanged during the stall.
  - Exactly 10 handshakes total.
  - Output matches the no-stall run.
- `num_steps`=0 frame followed immediately by a 4-step frame:
  - First frame: `frame_done` pulse with no `spike_valid`.
  - Second frame: spikes equal a fresh-reset 4-step run.
- `reset_n` low for 1 cycle at step 5 of 20:
  - All outputs return to reset values.
  - The next 20-step frame reproduces the sequence from seeds.
